// File: rtl/axi_dc_drain_pkg.sv
// Shared types and sizing helpers for the AXI dual-clock drain controller.
package axi_dc_drain_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2
  } drain_state_e;

  // Width needed to hold 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  // Width of the drain timer, which counts 0..cycles-1.
  function automatic int tmr_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/axi_dc_drain_cnt.sv
// Up/down outstanding-transaction counter with saturation and zero flags.
module axi_dc_drain_cnt
  import axi_dc_drain_pkg::*;
#(
  parameter int W         = 5,
  parameter int MAX       = 16,
  parameter bit IS_SIGNED = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         sat,
  output logic         zero
);

  logic do_inc;
  logic do_dec;

  assign sat  = (cnt == W'(MAX));
  assign zero = (cnt == '0);

  // Only the signed counter may go below zero (data phase ahead of address).
  assign do_inc = inc && !sat;
  assign do_dec = dec && (IS_SIGNED || !zero);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (do_inc && !do_dec) begin
      cnt <= cnt + 1'b1;
    end else if (do_dec && !do_inc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/axi_dc_drain_ctrl.sv
// Isolation controller: stalls AW/AR on request, drains in-flight bursts, then isolates.
// Optional drain timeout enabled by defining AXI_DC_DRAIN_TIMEOUT_EN.
module axi_dc_drain_ctrl
  import axi_dc_drain_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic isolate_req_i,
  output logic isolate_o,
  output logic isolated_o,
  input  logic aw_valid_i,
  output logic aw_ready_o,
  output logic aw_valid_o,
  input  logic aw_ready_i,
  input  logic ar_valid_i,
  output logic ar_ready_o,
  output logic ar_valid_o,
  input  logic ar_ready_i,
  input  logic w_valid_i,
  input  logic w_ready_i,
  input  logic w_last_i,
  input  logic b_valid_i,
  input  logic b_ready_i,
  input  logic r_valid_i,
  input  logic r_ready_i,
  input  logic r_last_i,
  output logic timeout_o
);

  localparam int CW  = cnt_width(MAX_OUTSTANDING);
  localparam int WBW = CW + 1;

  drain_state_e state, state_next;

  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         rd_cnt;
  logic signed [WBW-1:0] wb_cnt;
  logic wr_sat, rd_sat, wb_sat;
  logic wr_zero, rd_zero, wb_zero;
  logic all_zero;
  logic aw_open, ar_open;
  logic aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic timeout_fire;

  assign aw_valid_o = aw_valid_i && aw_open;
  assign aw_ready_o = aw_ready_i && aw_open;
  assign ar_valid_o = ar_valid_i && ar_open;
  assign ar_ready_o = ar_ready_i && ar_open;

  // Handshakes are observed on the slice side, so gated traffic is never counted.
  assign aw_hs = aw_valid_o && aw_ready_i;
  assign ar_hs = ar_valid_o && ar_ready_i;
  assign w_hs  = w_valid_i && w_ready_i && w_last_i;
  assign b_hs  = b_valid_i && b_ready_i;
  assign r_hs  = r_valid_i && r_ready_i && r_last_i;

  assign all_zero = wr_zero && rd_zero && wb_zero;

  axi_dc_drain_cnt #(.W(CW), .MAX(MAX_OUTSTANDING), .IS_SIGNED(1'b0)) u_wr (
    .clk(clk_i), .rst(rst_i), .clr(timeout_fire), .inc(aw_hs), .dec(b_hs),
    .cnt(wr_cnt), .sat(wr_sat), .zero(wr_zero)
  );

  axi_dc_drain_cnt #(.W(CW), .MAX(MAX_OUTSTANDING), .IS_SIGNED(1'b0)) u_rd (
    .clk(clk_i), .rst(rst_i), .clr(timeout_fire), .inc(ar_hs), .dec(r_hs),
    .cnt(rd_cnt), .sat(rd_sat), .zero(rd_zero)
  );

  axi_dc_drain_cnt #(.W(WBW), .MAX(MAX_OUTSTANDING), .IS_SIGNED(1'b1)) u_wb (
    .clk(clk_i), .rst(rst_i), .clr(timeout_fire), .inc(aw_hs), .dec(w_hs),
    .cnt(wb_cnt), .sat(wb_sat), .zero(wb_zero)
  );

`ifdef AXI_DC_DRAIN_TIMEOUT_EN
  localparam int TW = tmr_width(TIMEOUT_CYCLES);

  logic [TW-1:0] tmr;

  always_ff @(posedge clk_i) begin
    if (rst_i || (state != DRAIN)) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  // A normal drain completing in the same cycle takes precedence over the timeout.
  assign timeout_fire = (state == DRAIN) && isolate_req_i && !all_zero &&
                        (tmr == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_o <= 1'b0;
    end else if (timeout_fire) begin
      timeout_o <= 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= RUN;
      isolate_o  <= 1'b0;
      isolated_o <= 1'b0;
    end else begin
      state      <= state_next;
      isolate_o  <= (state_next == ISOLATED);
      isolated_o <= (state_next == ISOLATED);
    end
  end

  always_comb begin
    state_next = state;
    aw_open    = 1'b0;
    ar_open    = 1'b0;
    case (state)
      RUN: begin
        aw_open = !wr_sat && !wb_sat;
        ar_open = !rd_sat;
        if (isolate_req_i) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!isolate_req_i) begin
          state_next = RUN;
        end else if (all_zero || timeout_fire) begin
          state_next = ISOLATED;
        end
      end
      ISOLATED: begin
        if (!isolate_req_i) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_axi_dc_drain_ctrl.sv
// Directed bench for axi_dc_drain_ctrl (timeout scenario when AXI_DC_DRAIN_TIMEOUT_EN is defined).
module tb_axi_dc_drain_ctrl;
  import axi_dc_drain_pkg::*;

  logic clk = 1'b0;
  logic rst, isolate_req_i, isolate_o, isolated_o;
  logic aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
  logic ar_valid_i, ar_ready_o, ar_valid_o, ar_ready_i;
  logic w_valid_i, w_ready_i, w_last_i;
  logic b_valid_i, b_ready_i;
  logic r_valid_i, r_ready_i, r_last_i;
  logic timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_dc_drain_ctrl #(.MAX_OUTSTANDING(16), .TIMEOUT_CYCLES(20)) dut (
    .clk_i(clk), .rst_i(rst), .isolate_req_i(isolate_req_i),
    .isolate_o(isolate_o), .isolated_o(isolated_o),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .w_valid_i(w_valid_i), .w_ready_i(w_ready_i), .w_last_i(w_last_i),
    .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
    .timeout_o(timeout_o)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_aw(input logic v); aw_valid_i = v; aw_ready_i = v; endtask
  task automatic set_ar(input logic v); ar_valid_i = v; ar_ready_i = v; endtask
  task automatic set_w(input logic v);  w_valid_i = v; w_ready_i = v; w_last_i = v; endtask
  task automatic set_b(input logic v);  b_valid_i = v; b_ready_i = v; endtask
  task automatic set_r(input logic v, input logic last);
    r_valid_i = v; r_ready_i = v; r_last_i = last;
  endtask

  initial begin
    rst = 1'b1; isolate_req_i = 1'b0;
    set_aw(1'b0); set_ar(1'b0); set_w(1'b0); set_b(1'b0); set_r(1'b0, 1'b0);
    repeat (3) cyc();
    rst = 1'b0;
    cyc(); #1;
    chk("rst_isolate", isolate_o, 1'b0);
    chk("rst_isolated", isolated_o, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);
    chk("rst_state", dut.state, RUN);
    chk("rst_wr_cnt", dut.wr_cnt, 0);

    // Idle isolation: req in cycle n, blocked in n+1, isolate_o in n+2
    aw_valid_i = 1'b1; ar_valid_i = 1'b1; #1;
    chk("run_aw_pass", aw_valid_o, 1'b1);
    chk("run_aw_ready_follow", aw_ready_o, 1'b0);
    isolate_req_i = 1'b1; #1;
    chk("req_cycle_aw_pass", aw_valid_o, 1'b1);
    cyc(); #1;
    chk("drain_aw_blocked", aw_valid_o, 1'b0);
    chk("drain_ar_blocked", ar_valid_o, 1'b0);
    chk("drain_iso_low", isolate_o, 1'b0);
    cyc(); aw_ready_i = 1'b1; ar_ready_i = 1'b1; #1;
    chk("idle_iso_high", isolate_o, 1'b1);
    chk("idle_isolated_high", isolated_o, 1'b1);
    chk("iso_aw_valid_blocked", aw_valid_o, 1'b0);
    chk("iso_aw_ready_blocked", aw_ready_o, 1'b0);
    chk("iso_ar_ready_blocked", ar_ready_o, 1'b0);
    isolate_req_i = 1'b0; aw_ready_i = 1'b0; ar_ready_i = 1'b0;
    cyc(); #1;
    chk("release_iso_low", isolate_o, 1'b0);
    chk("release_aw_pass", aw_valid_o, 1'b1);
    chk("idle_no_count", dut.wr_cnt, 0);
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;

    // Two writes and one read outstanding, then drain
    cyc(); set_aw(1'b1); set_ar(1'b1); set_w(1'b1);
    cyc(); set_ar(1'b0);
    cyc(); set_aw(1'b0); set_w(1'b0); isolate_req_i = 1'b1; #1;
    chk("t2_wr_cnt", dut.wr_cnt, 2);
    chk("t2_rd_cnt", dut.rd_cnt, 1);
    chk("t2_wb_cnt", {26'd0, dut.wb_cnt}, 0);
    cyc(); #1;
    chk("t2_drain_iso0", isolate_o, 1'b0);
    cyc(); set_b(1'b1); #1;
    chk("t2_wait_iso0", isolate_o, 1'b0);
    cyc(); set_b(1'b0); set_r(1'b1, 1'b0); #1;
    chk("t2_wr_after_b", dut.wr_cnt, 1);
    cyc(); r_last_i = 1'b1; #1;
    chk("t2_rd_nonlast", dut.rd_cnt, 1);
    cyc(); set_r(1'b0, 1'b0); set_b(1'b1); #1;
    chk("t2_rd_after_last", dut.rd_cnt, 0);
    chk("t2_iso_wait_b", isolate_o, 1'b0);
    cyc(); set_b(1'b0); #1;
    chk("t2_wr_zero", dut.wr_cnt, 0);
    chk("t2_iso_not_yet", isolate_o, 1'b0);
    cyc(); #1;
    chk("t2_iso_high", isolate_o, 1'b1);
    isolate_req_i = 1'b0;
    cyc(); #1;
    chk("t2_iso_release", isolate_o, 1'b0);

    // W last ahead of its AW
    set_w(1'b1);
    cyc(); set_w(1'b0); #1;
    chk("t3_wb_neg", {26'd0, dut.wb_cnt}, 32'h3F);
    repeat (4) cyc();
    set_aw(1'b1);
    cyc(); set_aw(1'b0); #1;
    chk("t3_wb_zero", {26'd0, dut.wb_cnt}, 0);
    chk("t3_wr_one", dut.wr_cnt, 1);
    isolate_req_i = 1'b1;
    cyc();
    cyc(); #1;
    chk("t3_wait_b", isolate_o, 1'b0);
    set_b(1'b1);
    cyc(); set_b(1'b0); #1;
    chk("t3_wr_zero", dut.wr_cnt, 0);
    chk("t3_iso_not_yet", isolate_o, 1'b0);
    cyc(); #1;
    chk("t3_iso_high", isolate_o, 1'b1);
    isolate_req_i = 1'b0;
    cyc();

    // Write saturation at 16 outstanding
    set_aw(1'b1); set_w(1'b1);
    repeat (16) cyc();
    set_w(1'b0); #1;
    chk("t4_wr_full", dut.wr_cnt, 16);
    chk("t4_aw_ready_held", aw_ready_o, 1'b0);
    chk("t4_aw_valid_held", aw_valid_o, 1'b0);
    set_b(1'b1); #1;
    chk("t4_held_during_b", aw_ready_o, 1'b0);
    cyc(); set_b(1'b0); #1;
    chk("t4_wr_15", dut.wr_cnt, 15);
    chk("t4_aw_ready_released", aw_ready_o, 1'b1);
    chk("t4_aw_valid_released", aw_valid_o, 1'b1);
    cyc(); set_aw(1'b0); #1;
    chk("t4_wr_refull", dut.wr_cnt, 16);
    set_b(1'b1);
    repeat (16) cyc();
    set_b(1'b0); set_w(1'b1);
    cyc(); set_w(1'b0); #1;
    chk("t4_wr_drained", dut.wr_cnt, 0);
    chk("t4_wb_drained", {26'd0, dut.wb_cnt}, 0);

    // Read saturation at 16 outstanding
    set_ar(1'b1);
    repeat (16) cyc();
    #1;
    chk("t4_rd_full", dut.rd_cnt, 16);
    chk("t4_ar_ready_held", ar_ready_o, 1'b0);
    chk("t4_ar_valid_held", ar_valid_o, 1'b0);
    set_ar(1'b0); set_r(1'b1, 1'b1);
    repeat (16) cyc();
    set_r(1'b0, 1'b0); #1;
    chk("t4_rd_drained", dut.rd_cnt, 0);

    // Request withdrawn mid-drain with a read outstanding
    set_ar(1'b1);
    cyc(); set_ar(1'b0); isolate_req_i = 1'b1;
    cyc(); ar_valid_i = 1'b1; #1;
    chk("t5_drain_ar_blocked", ar_valid_o, 1'b0);
    chk("t5_drain_iso0", isolate_o, 1'b0);
    isolate_req_i = 1'b0;
    cyc(); #1;
    chk("t5_ar_pass_again", ar_valid_o, 1'b1);
    chk("t5_iso_never", isolate_o, 1'b0);
    chk("t5_state_run", dut.state, RUN);
    ar_valid_i = 1'b0; set_r(1'b1, 1'b1);
    cyc(); set_r(1'b0, 1'b0); #1;
    chk("t5_rd_zero", dut.rd_cnt, 0);

`ifdef AXI_DC_DRAIN_TIMEOUT_EN
    // Withheld B: timeout 20 cycles after entering DRAIN
    set_aw(1'b1); set_w(1'b1);
    cyc(); set_aw(1'b0); set_w(1'b0); isolate_req_i = 1'b1;
    cyc(); #1;
    chk("t6_in_drain", dut.state, DRAIN);
    for (int i = 1; i < 20; i++) begin
      cyc(); #1;
      chk("t6_waiting", {isolate_o, timeout_o}, 2'b00);
    end
    cyc(); #1;
    chk("t6_iso_high", isolate_o, 1'b1);
    chk("t6_timeout_high", timeout_o, 1'b1);
    chk("t6_wr_cleared", dut.wr_cnt, 0);
    isolate_req_i = 1'b0;
    cyc(); #1;
    chk("t6_timeout_sticky", timeout_o, 1'b1);
    chk("t6_iso_release", isolate_o, 1'b0);
`endif

    // Reset while draining
    set_ar(1'b1);
    cyc(); set_ar(1'b0); isolate_req_i = 1'b1;
    cyc();
    cyc(); #1;
    chk("t7_pre_rst_drain", dut.state, DRAIN);
    rst = 1'b1; isolate_req_i = 1'b0;
    cyc(); rst = 1'b0;
    cyc(); ar_valid_i = 1'b1; #1;
    chk("t7_rd_cleared", dut.rd_cnt, 0);
    chk("t7_state_run", dut.state, RUN);
    chk("t7_ar_pass", ar_valid_o, 1'b1);
    chk("t7_timeout_clear", timeout_o, 1'b0);
    ar_valid_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
